// File: rtl/issue_controller.sv
// Single-entry issue buffer between fetcher and decoder: gates decode on ROB/RS/LSB space,
// stalls behind an unresolved JALR and drops buffered work on a ROB clear.
module issue_controller #(
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  in_fetch_valid,
  input  logic [INST_WIDTH-1:0] in_fetch_inst,
  input  logic [ADDR_WIDTH-1:0] in_fetch_pc,
  output logic                  out_fetch_ready,
  output logic                  out_decode_enable,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  input  logic                  in_rob_full,
  input  logic                  in_rs_full,
  input  logic                  in_lsb_full,
  input  logic                  in_rob_clear,
  input  logic                  in_jalr_done,
  output logic                  out_stall_jalr,
  output logic [CNT_WIDTH-1:0]  out_stall_cycles
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    WAIT_JALR = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Memory ops occupy the LS buffer; everything else goes to a reservation station.
  function automatic logic need_met(input logic [6:0] op, input logic rob_full,
                                    input logic rs_full, input logic lsb_full);
    logic mem_op;
    mem_op = (op == OP_LOAD) || (op == OP_STORE);
    if (mem_op) begin
      need_met = !rob_full && !lsb_full;
    end else begin
      need_met = !rob_full && !rs_full;
    end
  endfunction

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [INST_WIDTH-1:0]  inst_r;
  logic [ADDR_WIDTH-1:0]  pc_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   active_s;
  logic                   issue_s;
  logic                   is_jalr_s;
  logic                   fetch_ready_s;
  logic                   transfer_s;
  logic                   stall_s;

  // Issue/handshake decode and next-state selection.
  always_comb begin
    active_s      = rdy_in && !rst_in && !in_rob_clear;
    issue_s       = active_s && (state_r == HOLD) &&
                    need_met(inst_r[6:0], in_rob_full, in_rs_full, in_lsb_full);
    is_jalr_s     = (inst_r[6:0] == OP_JALR);
    fetch_ready_s = active_s && ((state_r == IDLE) || (issue_s && !is_jalr_s));
    transfer_s    = in_fetch_valid && fetch_ready_s;
    stall_s       = active_s && (((state_r == HOLD) && !issue_s) || (state_r == WAIT_JALR));
    state_nxt_s   = state_r;
    if (!rdy_in) begin
      state_nxt_s = state_r;
    end else if (in_rob_clear) begin
      state_nxt_s = FLUSH;
    end else begin
      case (state_r)
        IDLE: begin
          if (transfer_s) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HOLD: begin
          if (issue_s && is_jalr_s) begin
            state_nxt_s = WAIT_JALR;
          end else if (issue_s) begin
            state_nxt_s = transfer_s ? HOLD : IDLE;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        WAIT_JALR: begin
          if (in_jalr_done) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT_JALR;
          end
        end
        FLUSH:   state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction buffer; only a fetch transfer overwrites it, so a stalled entry stays stable.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      inst_r <= {INST_WIDTH{1'b0}};
      pc_r   <= {ADDR_WIDTH{1'b0}};
    end else if (transfer_s) begin
      inst_r <= in_fetch_inst;
      pc_r   <= in_fetch_pc;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (stall_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign out_fetch_ready   = fetch_ready_s;
  assign out_decode_enable = issue_s;
  assign out_inst          = inst_r;
  assign out_pc            = pc_r;
  assign out_stall_jalr    = (state_r == WAIT_JALR);
  assign out_stall_cycles  = cnt_r;

endmodule
